// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu_bus control sequencer: opcodes, IR field positions, state encoding.
// Optional MUL/DIV support is selected elsewhere with the SEQ_MULDIV_EN macro.
package cpu_ctrl_pkg;

    localparam int OPC_W           = 5;
    localparam int RSEL_W          = 4;
    localparam int MEM_TIMEOUT_DEF = 15;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    typedef struct packed {
        logic is_binary;
        logic is_unary;
        logic is_muldiv;
        logic is_halt;
        logic is_illegal;
    } ir_class_t;

endpackage

// File: rtl/ir_class_decode.sv
// Combinational opcode classifier. With SEQ_MULDIV_EN undefined, MUL/DIV fall
// through to the illegal class.
module ir_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ir_class_t        cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: cls.is_binary  = 1'b1;
            OP_NEG, OP_NOT:                cls.is_unary   = 1'b1;
`ifdef SEQ_MULDIV_EN
            OP_MUL, OP_DIV:                cls.is_muldiv  = 1'b1;
`endif
            OP_HALT:                       cls.is_halt    = 1'b1;
            default:                       cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the cpu_bus datapath (fetch, decode, execute).
// SEQ_MULDIV_EN builds the MUL/DIV sequences and T6; otherwise those opcodes fault as illegal.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
)
(
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic             mem_rdy,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLowIn,
    output logic             ZHighIn,
    output logic             Zlowout,
    output logic             ZHighout,
    output logic             HIin,
    output logic             LOin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [OPC_W-1:0] alu_op,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             mem_fault,
    output state_t           state_dbg
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    ir_class_t        dec;
    logic             cls_binary;
    logic             cls_unary;
    logic             cls_muldiv;
    logic             unused_ir;

    assign unused_ir = ^IR[OPC_LSB-1:0];
    assign state_dbg = state;

    ir_class_decode u_decode (
        .opcode (IR[OPC_MSB:OPC_LSB]),
        .cls    (dec)
    );

    // Instruction class is captured as T2 exits so T3..T6 strobes depend on registers only.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            cls_binary <= 1'b0;
            cls_unary  <= 1'b0;
            cls_muldiv <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == S_T1 && !mem_rdy && wait_cnt != CNT_MAX) ? wait_cnt + 1'b1 : '0;
            if (state == S_T2) begin
                cls_binary <= dec.is_binary;
                cls_unary  <= dec.is_unary;
                cls_muldiv <= dec.is_muldiv;
            end
            if (state == S_T2 && state_next == S_HALTED) halted    <= 1'b1;
            if (state == S_T2 && state_next == S_FAULT)  illegal   <= 1'b1;
            if (state == S_T1 && state_next == S_FAULT)  mem_fault <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (Run) state_next = S_T0;
            S_T0:     state_next = S_T1;
            S_T1: begin
                if (mem_rdy)                   state_next = S_T2;
                else if (wait_cnt == CNT_MAX)  state_next = S_FAULT;
            end
            S_T2: begin
                if (dec.is_halt)         state_next = S_HALTED;
                else if (dec.is_illegal) state_next = S_FAULT;
                else                     state_next = S_T3;
            end
            S_T3:     state_next = S_T4;
            S_T4:     state_next = S_T5;
            S_T5: begin
                state_next = Run ? S_T0 : S_IDLE;
`ifdef SEQ_MULDIV_EN
                if (cls_muldiv) state_next = S_T6;
`endif
            end
`ifdef SEQ_MULDIV_EN
            S_T6:     state_next = Run ? S_T0 : S_IDLE;
`endif
            S_HALTED: state_next = S_HALTED;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin} = '0;
        {Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin}  = '0;
        {Gra, Grb, Grc, Rin, Rout}                             = '0;
        alu_op = '0;
        busy   = 1'b0;
        case (state)
            S_T0: begin
                busy = 1'b1;
                {PCout, MARin, IncPC, PCin} = 4'b1111;
            end
            S_T1: begin
                busy = 1'b1;
                {Read, MDRin} = 2'b11;
            end
            S_T2: begin
                busy = 1'b1;
                {MDRout, IRin} = 2'b11;
            end
            S_T3: begin
                busy = 1'b1;
                if (cls_binary) {Grb, Rout, Yin} = 3'b111;
                if (cls_muldiv) {Gra, Rout, Yin} = 3'b111;
            end
            S_T4: begin
                busy   = 1'b1;
                alu_op = IR[OPC_MSB:OPC_LSB];
                ZLowIn = 1'b1;
                Rout   = 1'b1;
                if (cls_binary)              Grc = 1'b1;
                if (cls_unary || cls_muldiv) Grb = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (cls_muldiv) ZHighIn = 1'b1;
`endif
            end
            S_T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                if (!cls_muldiv) {Gra, Rin} = 2'b11;
`ifdef SEQ_MULDIV_EN
                if (cls_muldiv) LOin = 1'b1;
`endif
            end
`ifdef SEQ_MULDIV_EN
            S_T6: begin
                busy = 1'b1;
                {ZHighout, HIin} = 2'b11;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute sequences, memory wait and timeout,
// illegal/HALT handling and Clear mid-instruction. Honours SEQ_MULDIV_EN like the RTL.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic        Clock, Clear, Run, mem_rdy;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        busy, halted, illegal, mem_fault;
    state_t      state_dbg;

    int checks = 0;
    int errors = 0;

    // Strobe vector bit positions, MSB first.
    localparam logic [19:0] B_PCOUT  = 20'h80000, B_PCIN   = 20'h40000, B_INCPC  = 20'h20000;
    localparam logic [19:0] B_MARIN  = 20'h10000, B_READ   = 20'h08000, B_MDRIN  = 20'h04000;
    localparam logic [19:0] B_MDROUT = 20'h02000, B_IRIN   = 20'h01000, B_YIN    = 20'h00800;
    localparam logic [19:0] B_ZLIN   = 20'h00400, B_ZHIN   = 20'h00200, B_ZLOUT  = 20'h00100;
    localparam logic [19:0] B_ZHOUT  = 20'h00080, B_HIIN   = 20'h00040, B_LOIN   = 20'h00020;
    localparam logic [19:0] B_GRA    = 20'h00010, B_GRB    = 20'h00008, B_GRC    = 20'h00004;
    localparam logic [19:0] B_RIN    = 20'h00002, B_ROUT   = 20'h00001;

    localparam logic [19:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_PCIN;
    localparam logic [19:0] E_T1 = B_READ | B_MDRIN;
    localparam logic [19:0] E_T2 = B_MDROUT | B_IRIN;

    logic [19:0] strobes;
    assign strobes = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                      Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin,
                      Gra, Grb, Grc, Rin, Rout};

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .mem_rdy(mem_rdy), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal),
        .mem_fault(mem_fault), .state_dbg(state_dbg)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [19:0] exp_s,
                              input logic exp_busy, input logic [4:0] exp_alu);
        check({tag, "_strobes"}, 32'(strobes), 32'(exp_s));
        check({tag, "_busy"},    32'(busy),    32'(exp_busy));
        check({tag, "_alu_op"},  32'(alu_op),  32'(exp_alu));
    endtask

    task automatic expect_flags(input string tag, input logic [2:0] exp_f);
        check({tag, "_flags"}, 32'({halted, illegal, mem_fault}), 32'(exp_f));
    endtask

    task automatic expect_state(input string tag, input state_t exp_st);
        check({tag, "_state"}, 32'(state_dbg), 32'(exp_st));
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        Run   = 1'b0;
        step();
        Clear = 1'b0;
    endtask

    task automatic fetch(input string tag);
        step(); expect_cyc({tag, "_t0"}, E_T0, 1'b1, 5'd0);
        step(); expect_cyc({tag, "_t1"}, E_T1, 1'b1, 5'd0);
        step(); expect_cyc({tag, "_t2"}, E_T2, 1'b1, 5'd0);
    endtask

    initial begin
        Clear = 1'b1; Run = 1'b0; mem_rdy = 1'b0; IR = 32'h0;
        step(); step();
        Clear = 1'b0;
        expect_cyc("reset", 20'h0, 1'b0, 5'd0);
        expect_state("reset", S_IDLE);
        expect_flags("reset", 3'b000);

        // AND R5,R2,R4 with Run held high: back-to-back into the next fetch
        IR = 32'h4A920000; mem_rdy = 1'b1; Run = 1'b1;
        fetch("and");
        step(); expect_cyc("and_t3", B_GRB | B_ROUT | B_YIN, 1'b1, 5'd0);
        step(); expect_cyc("and_t4", B_GRC | B_ROUT | B_ZLIN, 1'b1, 5'b01001);
        step(); expect_cyc("and_t5", B_ZLOUT | B_GRA | B_RIN, 1'b1, 5'd0);
        step(); expect_cyc("and_next_t0", E_T0, 1'b1, 5'd0);

        // Run drops in T0: NEG instruction still completes, with three mem wait cycles
        Run = 1'b0; mem_rdy = 1'b0; IR = 32'h89A00000;
        step();
        for (int i = 0; i < 4; i++) begin
            mem_rdy = (i == 3);
            expect_cyc("wait_t1", E_T1, 1'b1, 5'd0);
            step();
        end
        expect_cyc("wait_t2", E_T2, 1'b1, 5'd0);
        expect_flags("wait_nofault", 3'b000);
        step(); expect_cyc("neg_t3", 20'h0, 1'b1, 5'd0);
        step(); expect_cyc("neg_t4", B_GRB | B_ROUT | B_ZLIN, 1'b1, 5'b10001);
        step(); expect_cyc("neg_t5", B_ZLOUT | B_GRA | B_RIN, 1'b1, 5'd0);
        step(); expect_cyc("neg_idle", 20'h0, 1'b0, 5'd0);
        expect_state("neg_idle", S_IDLE);
        step(); expect_state("stay_idle", S_IDLE);

        // Memory timeout: 15 counted waits plus the cycle that sees the limit
        mem_rdy = 1'b0; Run = 1'b1;
        step(); expect_cyc("to_t0", E_T0, 1'b1, 5'd0);
        step();
        for (int i = 0; i < 15; i++) begin
            expect_cyc("to_wait", E_T1, 1'b1, 5'd0);
            step();
        end
        expect_cyc("to_last", E_T1, 1'b1, 5'd0);
        step();
        expect_cyc("to_fault", 20'h0, 1'b0, 5'd0);
        expect_state("to_fault", S_FAULT);
        expect_flags("to_fault", 3'b001);
        Run = 1'b0; step(); Run = 1'b1; mem_rdy = 1'b1; step();
        expect_cyc("to_hold", 20'h0, 1'b0, 5'd0);
        expect_state("to_hold", S_FAULT);
        do_clear();
        expect_state("to_clear", S_IDLE);
        expect_flags("to_clear", 3'b000);

        // MUL R1,R2
        IR = 32'h78900000; mem_rdy = 1'b1; Run = 1'b1;
        fetch("mul");
        Run = 1'b0;
`ifdef SEQ_MULDIV_EN
        step(); expect_cyc("mul_t3", B_GRA | B_ROUT | B_YIN, 1'b1, 5'd0);
        step(); expect_cyc("mul_t4", B_GRB | B_ROUT | B_ZLIN | B_ZHIN, 1'b1, 5'b01111);
        step(); expect_cyc("mul_t5", B_ZLOUT | B_LOIN, 1'b1, 5'd0);
        step(); expect_cyc("mul_t6", B_ZHOUT | B_HIIN, 1'b1, 5'd0);
        step(); expect_cyc("mul_idle", 20'h0, 1'b0, 5'd0);
        expect_state("mul_idle", S_IDLE);
        expect_flags("mul_idle", 3'b000);
`else
        step(); expect_cyc("mul_fault", 20'h0, 1'b0, 5'd0);
        expect_state("mul_fault", S_FAULT);
        expect_flags("mul_fault", 3'b010);
`endif
        do_clear();

        // Undefined opcode 11111
        IR = 32'hF8000000; Run = 1'b1;
        fetch("ill");
        step(); expect_cyc("ill_fault", 20'h0, 1'b0, 5'd0);
        expect_state("ill_fault", S_FAULT);
        expect_flags("ill_fault", 3'b010);
        Run = 1'b0; step(); Run = 1'b1; step();
        expect_state("ill_hold", S_FAULT);
        expect_cyc("ill_hold", 20'h0, 1'b0, 5'd0);
        do_clear();
        expect_state("ill_clear", S_IDLE);
        expect_flags("ill_clear", 3'b000);

        // HALT
        IR = 32'hD0000000; Run = 1'b1;
        fetch("halt");
        step(); expect_cyc("halt_done", 20'h0, 1'b0, 5'd0);
        expect_state("halt_done", S_HALTED);
        expect_flags("halt_done", 3'b100);
        step(); expect_state("halt_hold", S_HALTED);
        do_clear();
        expect_flags("halt_clear", 3'b000);

        // Clear during T4 of AND, then restart with Run high
        IR = 32'h4A920000; Run = 1'b1;
        fetch("clr");
        step(); expect_cyc("clr_t3", B_GRB | B_ROUT | B_YIN, 1'b1, 5'd0);
        step(); expect_cyc("clr_t4", B_GRC | B_ROUT | B_ZLIN, 1'b1, 5'b01001);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        expect_cyc("clr_idle", 20'h0, 1'b0, 5'd0);
        expect_state("clr_idle", S_IDLE);
        step(); expect_cyc("clr_restart", E_T0, 1'b1, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
